exec_ctrl: RTL

EXEC_CTRL -- requirements
Module: exec_ctrl

---
 rtl/exec_ctrl_pkg.sv | 23 ++
 rtl/exec_ctrl_btn_debounce.sv | 55 +++++
 rtl/exec_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/exec_ctrl_pkg.sv
// Shared definitions for the execution controller: FSM state encodings and
// the set of opcodes the datapath is allowed to execute.
package exec_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_STEP = 2'b10,
      ST_HALT = 2'b11
   } state_e;

   localparam logic [6:0] OP_ALU_R  = 7'b0110011;
   localparam logic [6:0] OP_ALU_I  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   function automatic logic is_legal_op(input logic [6:0] op);
      return (op == OP_ALU_R) || (op == OP_ALU_I) || (op == OP_LOAD) ||
             (op == OP_STORE) || (op == OP_BRANCH);
   endfunction

endpackage

// File: rtl/exec_ctrl_btn_debounce.sv
// Step push-button conditioning: 2-flop synchroniser, stability down-counter
// and a single-cycle event on each accepted press (button is active-low).
module btn_debounce #(
   parameter int DB_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic i_btn_n,
   output logic o_step_evt
);

   localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [DB_W-1:0] DB_RELOAD = DB_W'(DB_CYCLES - 1);

   logic            r_sync1;
   logic            r_sync2;
   logic            r_stable;
   logic            r_evt;
   logic [DB_W-1:0] r_cnt;

   logic w_diff;
   logic w_tc;
   logic w_accept;

   assign w_diff   = (r_sync2 != r_stable);
   assign w_tc     = (r_cnt == '0);
   assign w_accept = w_diff && w_tc;

   // Counter reloads whenever the input agrees with the accepted level, so
   // any bounce restarts the full stability window.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync1  <= 1'b0;
         r_sync2  <= 1'b0;
         r_stable <= 1'b1;
         r_cnt    <= DB_RELOAD;
         r_evt    <= 1'b0;
      end else begin
         r_sync1 <= i_btn_n;
         r_sync2 <= r_sync1;
         r_evt   <= w_accept && !r_sync2;
         if (!w_diff || w_tc) begin
            r_cnt <= DB_RELOAD;
         end else begin
            r_cnt <= r_cnt - 1'b1;
         end
         if (w_accept) begin
            r_stable <= r_sync2;
         end
      end
   end

   assign o_step_evt = r_evt;

endmodule

// File: rtl/exec_ctrl.sv
// Run/step/breakpoint execution controller gating the CPU datapath.
// state | meaning
// IDLE  | stopped, waiting for run_sw or a step press
// RUN   | free-running, one instruction per cycle
// STEP  | single instruction, then back to IDLE
// HALT  | stopped by breakpoint (resumable) or illegal opcode (reset only)
module exec_ctrl
   import exec_ctrl_pkg::*;
#(
   parameter int DB_CYCLES = 16,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run_sw,
   input  logic             step_btn,
   input  logic             bp_en,
   input  logic [7:0]       bp_addr,
   input  logic [7:0]       pc,
   input  logic [6:0]       opcode,
   output logic             cpu_en,
   output logic [1:0]       state,
   output logic             illegal,
   output logic [CNT_W-1:0] instr_cnt
);

   logic             r_run_s1;
   logic             r_run_s2;
   state_e           r_state;
   logic             r_illegal;
   logic             r_bp_armed;
   logic [CNT_W-1:0] r_instr_cnt;

   state_e w_next;
   logic   w_cpu_en;
   logic   w_step_evt;
   logic   w_active;
   logic   w_illegal_op;
   logic   w_bp_hit;
   logic   w_stop;

   btn_debounce #(
      .DB_CYCLES (DB_CYCLES)
   ) u_btn_debounce (
      .clk        (clk),
      .rst        (rst),
      .i_btn_n    (step_btn),
      .o_step_evt (w_step_evt)
   );

   assign w_active     = (r_state == ST_RUN) || (r_state == ST_STEP);
   assign w_illegal_op = !is_legal_op(opcode);
   assign w_bp_hit     = (r_state == ST_RUN) && bp_en && (pc == bp_addr) && r_bp_armed;
   assign w_stop       = w_illegal_op || w_bp_hit;

   always_comb begin
      w_next   = r_state;
      w_cpu_en = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (r_run_s2) begin
               w_next = ST_RUN;
            end else if (w_step_evt) begin
               w_next = ST_STEP;
            end
         end
         ST_RUN: begin
            if (w_stop) begin
               w_next = ST_HALT;
            end else begin
               w_cpu_en = 1'b1;
               if (!r_run_s2) begin
                  w_next = ST_IDLE;
               end
            end
         end
         ST_STEP: begin
            if (w_stop) begin
               w_next = ST_HALT;
            end else begin
               w_cpu_en = 1'b1;
               w_next   = ST_IDLE;
            end
         end
         ST_HALT: begin
            if (!r_illegal) begin
               if (w_step_evt) begin
                  w_next = ST_STEP;
               end else if (!r_run_s2) begin
                  w_next = ST_IDLE;
               end
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Breakpoint disarms on the hit so the resuming instruction at the same
   // PC can execute; the first executed cycle afterwards re-arms it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_run_s1    <= 1'b0;
         r_run_s2    <= 1'b0;
         r_state     <= ST_IDLE;
         r_illegal   <= 1'b0;
         r_bp_armed  <= 1'b1;
         r_instr_cnt <= '0;
      end else begin
         r_run_s1 <= run_sw;
         r_run_s2 <= r_run_s1;
         r_state  <= w_next;
         if (w_active && w_illegal_op) begin
            r_illegal <= 1'b1;
         end
         if (w_bp_hit) begin
            r_bp_armed <= 1'b0;
         end else if (w_cpu_en) begin
            r_bp_armed <= 1'b1;
         end
         if (w_cpu_en && (r_instr_cnt != '1)) begin
            r_instr_cnt <= r_instr_cnt + 1'b1;
         end
      end
   end

   assign cpu_en    = w_cpu_en;
   assign state     = r_state;
   assign illegal   = r_illegal;
   assign instr_cnt = r_instr_cnt;

endmodule
